// File: rtl/axiline_pkg.sv
// Shared types and saturation limits for the axiline dot-product datapath.
// Limits are functions of the accumulator width so every instance derives its own clamp values.
package axiline_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/dot_feeder_if.sv
// Element-in / result-out handshake bundle between the sample source, dot_feeder and the gradient stage.
interface dot_feeder_if #(
  parameter int bitwidth      = 32,
  parameter int inputBitwidth = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [inputBitwidth-1:0] feature;
  logic [inputBitwidth-1:0] weight;
  logic [inputBitwidth-1:0] label;
  logic                     out_valid;
  logic                     out_ready;
  logic [bitwidth-1:0]      data_out;
  logic [inputBitwidth-1:0] bias_out;

  modport master (
    output in_valid, feature, weight, label, out_ready,
    input  in_ready, out_valid, data_out, bias_out
  );

  modport slave (
    input  in_valid, feature, weight, label, out_ready,
    output in_ready, out_valid, data_out, bias_out
  );
endinterface

// File: rtl/dot_mac.sv
// Combinational multiply-accumulate step: acc + sext(feature*weight).
// Define SATURATE_EN to clamp the sum to the signed accumulator range instead of wrapping.
module dot_mac
  import axiline_pkg::*;
#(
  parameter int bitwidth      = 32,
  parameter int inputBitwidth = 16
) (
  input  logic signed [bitwidth-1:0]      acc,
  input  logic signed [inputBitwidth-1:0] feature,
  input  logic signed [inputBitwidth-1:0] weight,
  output logic signed [bitwidth-1:0]      sum
);

  logic signed [2*inputBitwidth-1:0] prod;
  assign prod = feature * weight;

`ifdef SATURATE_EN
  // One guard bit above the wider operand so overflow is visible before clamping.
  localparam int W = ((bitwidth > 2*inputBitwidth) ? bitwidth : 2*inputBitwidth) + 1;
  localparam logic signed [W-1:0] LIM_MAX = W'(sat_max(bitwidth));
  localparam logic signed [W-1:0] LIM_MIN = W'(sat_min(bitwidth));

  logic signed [W-1:0] full;
  assign full = W'(acc) + W'(prod);

  always_comb begin
    if (full > LIM_MAX)
      sum = bitwidth'(LIM_MAX);
    else if (full < LIM_MIN)
      sum = bitwidth'(LIM_MIN);
    else
      sum = bitwidth'(full);
  end
`else
  assign sum = acc + bitwidth'(prod);
`endif

endmodule

// File: rtl/dot_feeder.sv
// Streams VECTOR_LEN feature/weight pairs into a dot product and hands the result plus label onward.
// Accumulation saturates when SATURATE_EN is defined, otherwise wraps two's complement.
module dot_feeder
  import axiline_pkg::*;
#(
  parameter int bitwidth      = 32,
  parameter int inputBitwidth = 16,
  parameter int VECTOR_LEN    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  dot_feeder_if.slave   bus
);

  localparam int CNT_W = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VECTOR_LEN - 1);

  state_t state_reg, state_next;
  logic [CNT_W-1:0]               cnt_reg;
  logic signed [bitwidth-1:0]      acc_reg;
  logic signed [bitwidth-1:0]      sum;
  logic [bitwidth-1:0]             data_reg;
  logic [inputBitwidth-1:0]        bias_reg;
  logic                            in_ready;
  logic                            out_valid;
  logic                            accept;
  logic                            last_elem;

  assign accept    = bus.in_valid & in_ready;
  assign last_elem = accept & (cnt_reg == LAST_IDX);

  dot_mac #(
    .bitwidth      (bitwidth),
    .inputBitwidth (inputBitwidth)
  ) u_mac (
    .acc     (acc_reg),
    .feature (bus.feature),
    .weight  (bus.weight),
    .sum     (sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= ACC;
    else
      state_reg <= state_next;
  end

  // clear outranks both handshakes.
  always_comb begin
    state_next = state_reg;
    if (clear)
      state_next = ACC;
    else begin
      case (state_reg)
        ACC:     if (last_elem) state_next = DONE;
        DONE:    if (bus.out_ready) state_next = ACC;
        default: state_next = ACC;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      ACC:     in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Result registers only load on the last element, so they hold through DONE and beyond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg  <= '0;
      cnt_reg  <= '0;
      data_reg <= '0;
      bias_reg <= '0;
    end else if (clear) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (accept) begin
      acc_reg <= sum;
      if (last_elem) begin
        data_reg <= sum;
        bias_reg <= bus.label;
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end else if (out_valid && bus.out_ready) begin
      acc_reg <= '0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.data_out  = data_reg;
  assign bus.bias_out  = bias_reg;

endmodule

// File: tb/tb_dot_feeder.sv
// Directed bench for dot_feeder (VECTOR_LEN=4, 32/16-bit); expectations follow SATURATE_EN.
module tb_dot_feeder;

  logic clk;
  logic rst;
  logic clear;
  int   n_checks;
  int   n_fail;

  dot_feeder_if #(.bitwidth(32), .inputBitwidth(16)) bus ();

  dot_feeder #(
    .bitwidth      (32),
    .inputBitwidth (16),
    .VECTOR_LEN    (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_elem(input int f, input int w, input int l);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.feature  = 16'(f);
    bus.weight   = 16'(w);
    bus.label    = 16'(l);
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.in_ready) check_value("in_ready_wait", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_sample(input int f[4], input int w[4], input int l, input bit gap);
    for (int i = 0; i < 4; i++) begin
      send_elem(f[i], w[i], (i == 3) ? l : l + 100);
      if (gap && i != 3) tick();
    end
  endtask

  task automatic check_result(input string tag, input logic signed [63:0] exp_data,
                              input logic signed [63:0] exp_bias);
    check_value({tag, "_valid"}, bus.out_valid, 1);
    check_value({tag, "_data"}, $signed(bus.data_out), exp_data);
    check_value({tag, "_bias"}, $signed(bus.bias_out), exp_bias);
    $display("sample %s: data_out=%0d bias_out=%0d", tag, $signed(bus.data_out),
             $signed(bus.bias_out));
  endtask

  initial begin
    logic signed [63:0] exp_pos;
    logic signed [63:0] exp_neg;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.feature = '0;
    bus.weight = '0;
    bus.label = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check_value("rst_out_valid", bus.out_valid, 0);
    check_value("rst_data", $signed(bus.data_out), 0);
    check_value("rst_bias", $signed(bus.bias_out), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_value("rst_in_ready", bus.in_ready, 1);

    // basic sample, result visible one cycle after last element, held for one cycle
    send_sample('{1, 2, 3, 4}, '{5, 6, 7, 8}, 9, 1'b0);
    check_result("basic", 70, 9);
    check_value("basic_in_ready", bus.in_ready, 0);
    tick();
    check_value("basic_drop_valid", bus.out_valid, 0);
    check_value("basic_in_ready_back", bus.in_ready, 1);
    check_value("basic_hold_data", $signed(bus.data_out), 70);

    // backpressure with elements offered during DONE
    bus.out_ready = 1'b0;
    send_sample('{1, 2, 3, 4}, '{5, 6, 7, 8}, 9, 1'b0);
    check_result("stall", 70, 9);
    bus.in_valid = 1'b1;
    bus.feature = 16'd100;
    bus.weight = 16'd100;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_value("stall_data", $signed(bus.data_out), 70);
      check_value("stall_in_ready", bus.in_ready, 0);
      check_value("stall_valid", bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check_value("stall_release", bus.out_valid, 0);
    send_sample('{-1, -1, -1, -1}, '{2, 2, 2, 2}, 3, 1'b0);
    check_result("neg", -8, 3);
    tick();

    // clear after two elements
    send_elem(5, 5, 0);
    send_elem(5, 5, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_value("clear_valid", bus.out_valid, 0);
    check_value("clear_in_ready", bus.in_ready, 1);
    send_sample('{1, 1, 1, 1}, '{1, 1, 1, 1}, 4, 1'b0);
    check_result("after_clear", 4, 4);
    tick();

    // clear coinciding with the last element wins over the handshake
    send_elem(7, 7, 0);
    send_elem(7, 7, 0);
    send_elem(7, 7, 0);
    bus.in_valid = 1'b1;
    bus.feature = 16'd7;
    bus.weight = 16'd7;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bus.in_valid = 1'b0;
    check_value("clear_prio_valid", bus.out_valid, 0);
    check_value("clear_prio_data", $signed(bus.data_out), 4);
    send_sample('{1, 1, 1, 1}, '{1, 1, 1, 1}, 5, 1'b0);
    check_result("clear_prio_next", 4, 5);
    tick();

    // overflow behaviour
`ifdef SATURATE_EN
    exp_pos = 64'sd2147483647;
    exp_neg = -64'sd2147483648;
`else
    exp_pos = -64'sd262140;
    exp_neg = 64'sd131072;
`endif
    send_sample('{32767, 32767, 32767, 32767}, '{32767, 32767, 32767, 32767}, 1, 1'b0);
    check_result("ovf_pos", exp_pos, 1);
    tick();
    send_sample('{-32768, -32768, -32768, -32768}, '{32767, 32767, 32767, 32767}, 2, 1'b0);
    check_result("ovf_neg", exp_neg, 2);
    tick();

    // reset while holding a result
    bus.out_ready = 1'b0;
    send_sample('{1, 2, 3, 4}, '{5, 6, 7, 8}, 9, 1'b0);
    check_result("pre_rst", 70, 9);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_value("mid_rst_valid", bus.out_valid, 0);
    check_value("mid_rst_data", $signed(bus.data_out), 0);
    check_value("mid_rst_bias", $signed(bus.bias_out), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check_value("post_rst_in_ready", bus.in_ready, 1);

    // reset abandons a partial sample
    send_elem(9, 9, 0);
    send_elem(9, 9, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_sample('{1, 1, 1, 1}, '{1, 1, 1, 1}, 6, 1'b0);
    check_result("post_rst_sample", 4, 6);
    tick();

    // gapped stream matches back-to-back result
    send_sample('{1, 2, 3, 4}, '{5, 6, 7, 8}, 9, 1'b1);
    check_result("gapped", 70, 9);
    tick();
    check_value("gapped_drop_valid", bus.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dot_feeder.md
DOT_FEEDER -- requirements
Module: dot_feeder

Interface
REQ-001 SHALL have parameter bitwidth, default 32, accumulator and result width.
REQ-002 SHALL have parameter inputBitwidth, default 16, feature/weight/label width.
REQ-003 SHALL have parameter VECTOR_LEN, default 8, number of elements per sample (>=1).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port clear  input  1  synchronous abort of the current sample.
REQ-007 SHALL have ports in_valid input 1 and in_ready output 1, the element handshake.
REQ-008 SHALL have ports feature input inputBitwidth and weight input inputBitwidth, signed element operands.
REQ-009 SHALL have port label  input  inputBitwidth  sample label, sampled with the last element.
REQ-010 SHALL have ports out_valid output 1 and out_ready input 1, the result handshake toward the combinational gradient stage.
REQ-011 SHALL have port data_out  output  bitwidth  signed dot product, driven to the gradient stage data input.
REQ-012 SHALL have port bias_out  output  inputBitwidth  registered label, driven to the gradient stage bias input.

Function
REQ-013 SHALL implement two states: ACC (accepting elements) and DONE (holding a result).
REQ-014 SHALL assert in_ready=1 only in ACC and out_valid=1 only in DONE.
REQ-015 SHALL, on an accepted element (in_valid&in_ready), add sign-extended feature*weight (2*inputBitwidth product) to the accumulator and increment the element counter.
REQ-016 SHALL, on the element accepted with counter==VECTOR_LEN-1, register the final sum into data_out, register label into bias_out, clear the counter and go to DONE on the next edge (1-cycle latency from last element to out_valid).
REQ-017 SHALL hold data_out and bias_out stable while out_valid=1 and out_ready=0.
REQ-018 SHALL, on out_valid&out_ready, clear the accumulator and return to ACC; in_ready SHALL rise the following cycle (no same-cycle element acceptance in DONE).
REQ-019 SHALL ignore in_valid while in ACC with in_ready=0 never occurring; elements offered in DONE SHALL NOT be consumed.
REQ-020 SHALL, on clear=1 in any state, clear accumulator and counter, deassert out_valid and enter ACC next edge; clear SHALL take priority over both handshakes in the same cycle.
REQ-021 SHALL wrap the counter to 0 after VECTOR_LEN elements; with VECTOR_LEN=1 every accepted element produces a result.
REQ-022 SHALL keep data_out and bias_out at their last values when out_valid=0.

Reset
REQ-023 SHALL, while rst=1, force state ACC, counter 0, accumulator 0, data_out 0, bias_out 0, out_valid 0; in_ready SHALL be 1 after rst deasserts.
REQ-024 SHALL abandon any partial sample or held result when rst asserts mid-operation.

Configuration
REQ-025 SHALL, with SATURATE_EN defined, clamp each accumulation to signed bitwidth max (2^(bitwidth-1)-1) / min (-2^(bitwidth-1)).
REQ-026 SHALL, without SATURATE_EN, wrap accumulation modulo 2^bitwidth (two's complement).

Structure
REQ-027 SHALL place the state encoding (ACC, DONE) and the saturation limit constants in the shared package axiline_pkg.
REQ-028 SHALL use one sub-module dot_mac: combinational multiply, sign-extend, add, optional saturate.

Verification (VECTOR_LEN=4, bitwidth=32, inputBitwidth=16)
REQ-029 SHALL cover: features {1,2,3,4}, weights {5,6,7,8}, label 9, out_ready=1 -> data_out=70, bias_out=9, out_valid for 1 cycle, one cycle after the 4th element.
REQ-030 SHALL cover: same sample with out_ready=0 for 5 cycles -> data_out=70 stable, in_ready=0, in_valid elements not consumed; next sample {-1,-1,-1,-1}x{2,2,2,2} -> data_out=-8.
REQ-031 SHALL cover: clear asserted after 2 elements, then full sample {1,1,1,1}x{1,1,1,1} -> data_out=4 (no leftover from aborted sample).
REQ-032 SHALL cover: features all 32767, weights all 32767 with bitwidth=32 -> 4294705156 wraps to -262140 without SATURATE_EN, 2147483647 with SATURATE_EN.
REQ-033 SHALL cover: rst pulsed while out_valid=1 -> out_valid=0, data_out=0, bias_out=0 immediately; in_ready=1 after release.
REQ-034 SHALL cover: in_valid toggling every other cycle -> result identical to back-to-back streaming (70 for REQ-029 data).
